load_store_queue: RTL

LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

---
 rtl/load_store_queue.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_queue.sv
// load_store_queue: in-order load/store queue between the issue stage and memory.
// Entries wait for their operands via CDB snooping, stores also wait for ROB
// commit, and the head entry is sent to memory one request at a time.
module load_store_queue #(
    parameter int DEPTH_LOG = 3,
    parameter int TAG_W     = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             issue_valid,
    input  logic             issue_store,
    input  logic [2:0]       issue_funct3,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic [TAG_W-1:0] issue_qk,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             full_out,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic             flush_in,
    output logic             mem_req_valid,
    output logic             mem_req_we,
    output logic [1:0]       mem_req_size,
    output logic [31:0]      mem_req_addr,
    output logic [31:0]      mem_req_wdata,
    input  logic             mem_done,
    input  logic [31:0]      mem_rdata,
    output logic             result_valid,
    output logic [TAG_W-1:0] result_tag,
    output logic [31:0]      result_value
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] COUNT_FULL = (DEPTH_LOG + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_drop;
    logic [DEPTH_LOG-1:0] r_head;
    logic [DEPTH_LOG-1:0] r_tail;
    logic [DEPTH_LOG:0]   r_count;
    logic [DEPTH-1:0]     r_occ;
    logic [DEPTH-1:0]     r_committed;

    logic                 r_store  [DEPTH];
    logic [2:0]           r_funct3 [DEPTH];
    logic [31:0]          r_imm    [DEPTH];
    logic [31:0]          r_vj     [DEPTH];
    logic [31:0]          r_vk     [DEPTH];
    logic [TAG_W-1:0]     r_qj     [DEPTH];
    logic [TAG_W-1:0]     r_qk     [DEPTH];
    logic [TAG_W-1:0]     r_tag    [DEPTH];

    logic                 r_memReqValid;
    logic                 r_memReqWe;
    logic [1:0]           r_memReqSize;
    logic [31:0]          r_memReqAddr;
    logic [31:0]          r_memReqWdata;

    logic                 w_full;
    logic                 w_flush;
    logic                 w_deq;
    logic                 w_enq;
    logic                 w_headReady;
    logic                 w_launch;
    logic                 w_capJ;
    logic                 w_capK;
    logic [DEPTH-1:0]     w_commitHit;
    logic [DEPTH-1:0]     w_occNext;
    logic [DEPTH-1:0]     w_commNext;
    logic [DEPTH_LOG:0]   w_nKept;
    logic [DEPTH_LOG-1:0] w_headNext;
    logic [31:0]          w_loadData;

    // Queue control: a slot freed by this cycle's dequeue may be refilled at once,
    // and a flush blocks issue in the same cycle.
    assign w_full     = (r_count == COUNT_FULL);
    assign w_flush    = rdy_in && flush_in;
    assign w_deq      = rdy_in && (r_state == S_WAIT) && mem_done && !r_drop;
    assign w_enq      = rdy_in && issue_valid && !flush_in && (!w_full || w_deq);
    assign w_headNext = r_head + DEPTH_LOG'(w_deq);
    assign w_capJ     = cdb_valid && (issue_qj != '0) && (cdb_tag == issue_qj);
    assign w_capK     = cdb_valid && (issue_qk != '0) && (cdb_tag == issue_qk);

    // The head may go to memory once its base is known; a store additionally
    // needs its data and the ROB's commit. A flush cycle never launches, so a
    // load about to be removed is not sent.
    assign w_headReady = r_occ[r_head] && (r_qj[r_head] == '0) &&
                         (!r_store[r_head] || ((r_qk[r_head] == '0) && r_committed[r_head]));
    assign w_launch    = rdy_in && (r_state == S_IDLE) && w_headReady && !flush_in;

    // Next occupied/committed flags: commit marks, dequeue frees the head, flush
    // keeps only committed stores (always the oldest, so they stay contiguous
    // from the head), enqueue claims the tail slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_commitHit[i] = commit_valid && r_occ[i] && r_store[i] && (r_tag[i] == commit_tag);
        end
        w_occNext  = r_occ;
        w_commNext = r_committed | w_commitHit;
        if (w_deq) begin
            w_occNext[r_head]  = 1'b0;
            w_commNext[r_head] = 1'b0;
        end
        if (w_flush) begin
            w_occNext  = w_occNext & w_commNext;
            w_commNext = w_commNext & w_occNext;
        end
        if (w_enq) begin
            w_occNext[r_tail]  = 1'b1;
            w_commNext[r_tail] = 1'b0;
        end
        w_nKept = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_occNext[i]) begin
                w_nKept = w_nKept + (DEPTH_LOG + 1)'(1);
            end
        end
    end

    // Load data is right-aligned; extend it according to the entry's funct3.
    always_comb begin
        case (r_funct3[r_head])
            3'b000:  w_loadData = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  w_loadData = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b100:  w_loadData = {24'h0, mem_rdata[7:0]};
            3'b101:  w_loadData = {16'h0, mem_rdata[15:0]};
            default: w_loadData = mem_rdata;
        endcase
    end

    // Pointers, flags and the memory FSM; everything freezes while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state       <= S_IDLE;
            r_drop        <= 1'b0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_occ         <= '0;
            r_committed   <= '0;
            r_memReqValid <= 1'b0;
            r_memReqWe    <= 1'b0;
            r_memReqSize  <= 2'b00;
            r_memReqAddr  <= 32'h0;
            r_memReqWdata <= 32'h0;
        end else if (rdy_in) begin
            r_occ       <= w_occNext;
            r_committed <= w_commNext;
            r_head      <= w_headNext;
            if (w_flush) begin
                r_tail  <= w_headNext + w_nKept[DEPTH_LOG-1:0];
                r_count <= w_nKept;
            end else begin
                if (w_enq) begin
                    r_tail <= r_tail + DEPTH_LOG'(1);
                end
                r_count <= r_count + (DEPTH_LOG + 1)'(w_enq) - (DEPTH_LOG + 1)'(w_deq);
            end
            case (r_state)
                S_IDLE: begin
                    r_memReqValid <= w_launch;
                    if (w_launch) begin
                        r_state       <= S_WAIT;
                        r_memReqWe    <= r_store[r_head];
                        r_memReqSize  <= r_funct3[r_head][1:0];
                        r_memReqAddr  <= r_vj[r_head] + r_imm[r_head];
                        r_memReqWdata <= r_vk[r_head];
                    end
                end
                S_WAIT: begin
                    r_memReqValid <= 1'b0;
                    if (mem_done) begin
                        r_state <= S_IDLE;
                        r_drop  <= 1'b0;
                    end else if (flush_in && !r_memReqWe) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Entry payload: CDB snooping on waiting operands, then the new entry at the
    // tail (written last so it wins over a snoop on a slot freed this cycle).
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_valid && r_occ[i] && (r_qj[i] != '0) && (r_qj[i] == cdb_tag)) begin
                    r_vj[i] <= cdb_value;
                    r_qj[i] <= '0;
                end
                if (cdb_valid && r_occ[i] && (r_qk[i] != '0) && (r_qk[i] == cdb_tag)) begin
                    r_vk[i] <= cdb_value;
                    r_qk[i] <= '0;
                end
            end
            if (w_enq) begin
                r_store[r_tail]  <= issue_store;
                r_funct3[r_tail] <= issue_funct3;
                r_imm[r_tail]    <= issue_imm;
                r_tag[r_tail]    <= issue_tag;
                r_vj[r_tail]     <= w_capJ ? cdb_value : issue_vj;
                r_qj[r_tail]     <= w_capJ ? '0 : issue_qj;
                r_vk[r_tail]     <= w_capK ? cdb_value : issue_vk;
                r_qk[r_tail]     <= w_capK ? '0 : issue_qk;
            end
        end
    end

    // A load writes back in the cycle its response arrives, unless it was flushed.
    assign result_valid  = w_deq && !r_memReqWe && !flush_in;
    assign result_tag    = result_valid ? r_tag[r_head] : '0;
    assign result_value  = result_valid ? w_loadData : 32'h0;

    assign full_out      = w_full;
    assign mem_req_valid = r_memReqValid;
    assign mem_req_we    = r_memReqWe;
    assign mem_req_size  = r_memReqSize;
    assign mem_req_addr  = r_memReqAddr;
    assign mem_req_wdata = r_memReqWdata;

endmodule
